// File: rtl/NanoCore_pkg.sv
// NanoCore_pkg: shared types and constants for the NanoCore data-memory bridge.
package NanoCore_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/n2_dmem_bridge.sv
// n2_dmem_bridge: LSU req/gnt channel to a 1-cycle SRAM, in-order single-pulse responses.
// Define N2_DMEM_MMIO_EN to add the MMIO window, its WAIT/RESP FSM, timeout counter and bus_err_o.
module n2_dmem_bridge
    import NanoCore_pkg::*;
#(
    parameter int unsigned SRAM_AW   = 14,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [31:0] MMIO_MASK = 32'hF000_0000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               data_req_i,
    input  logic               data_we_i,
    input  logic [31:0]        data_addr_i,
    input  logic [31:0]        data_wdata_i,
    input  logic [3:0]         data_wstrb_i,
    output logic               data_gnt_o,
    output logic               data_ready_o,
    output logic [31:0]        data_rdata_o,
    output logic               sram_cs_o,
    output logic [3:0]         sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    input  logic [31:0]        sram_rdata_i,
    output logic               mmio_req_o,
    output logic               mmio_we_o,
    output logic [31:0]        mmio_addr_o,
    output logic [31:0]        mmio_wdata_o,
    output logic [3:0]         mmio_wstrb_o,
    input  logic               mmio_ack_i,
    input  logic [31:0]        mmio_rdata_i,
    output logic               bus_err_o
);
    dmem_state_e state;
    logic        is_mmio;
    logic        sram_hit;
    logic        pend;
    logic        pend_we;
    logic [31:0] resp_data;
    logic        resp_err;

    assign data_gnt_o   = data_req_i & (state == IDLE | state == RESP);
    assign sram_hit     = data_gnt_o & ~is_mmio;
    assign sram_cs_o    = sram_hit;
    assign sram_we_o    = sram_hit ? (data_wstrb_i & {4{data_we_i}}) : 4'b0;
    assign sram_addr_o  = data_addr_i[SRAM_AW+1:2];
    assign sram_wdata_o = data_wdata_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend    <= 1'b0;
            pend_we <= 1'b0;
        end else begin
            pend    <= sram_hit;
            pend_we <= data_we_i;
        end
    end

    // An SRAM response and a RESP cycle never overlap since nothing is granted in WAIT.
    assign data_ready_o = pend | (state == RESP);
    assign data_rdata_o = pend ? (pend_we ? 32'h0 : sram_rdata_i)
                               : ((state == RESP && !mmio_we_o) ? resp_data : 32'h0);
    assign bus_err_o    = (state == RESP) & resp_err;

`ifdef N2_DMEM_MMIO_EN
    dmem_state_e state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic        mmio_go;
    logic        wait_done;

    assign is_mmio    = (data_addr_i & MMIO_MASK) == MMIO_BASE;
    assign mmio_go    = data_gnt_o & is_mmio;
    assign wait_done  = mmio_ack_i | (cnt == TIMEOUT);
    assign mmio_req_o = state == WAIT;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = mmio_go ? 8'd0 : ((state == WAIT) ? cnt + 8'd1 : cnt);
        case (state)
            IDLE, RESP: state_nxt = mmio_go ? WAIT : IDLE;
            WAIT:       state_nxt = wait_done ? RESP : WAIT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            resp_data    <= 32'h0;
            resp_err     <= 1'b0;
            mmio_we_o    <= 1'b0;
            mmio_addr_o  <= 32'h0;
            mmio_wdata_o <= 32'h0;
            mmio_wstrb_o <= 4'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (mmio_go) begin
                mmio_we_o    <= data_we_i;
                mmio_addr_o  <= data_addr_i;
                mmio_wdata_o <= data_wdata_i;
                mmio_wstrb_o <= data_wstrb_i;
            end
            // Ack in the timeout cycle wins over the forced error.
            if (state == WAIT && wait_done) begin
                resp_data <= mmio_ack_i ? mmio_rdata_i : DMEM_ERR_DATA;
                resp_err  <= ~mmio_ack_i;
            end
        end
    end
`else
    logic unused_mmio;

    assign is_mmio      = 1'b0;
    assign state        = IDLE;
    assign resp_data    = 32'h0;
    assign resp_err     = 1'b0;
    assign mmio_req_o   = 1'b0;
    assign mmio_we_o    = 1'b0;
    assign mmio_addr_o  = 32'h0;
    assign mmio_wdata_o = 32'h0;
    assign mmio_wstrb_o = 4'b0;
    assign unused_mmio  = ^{mmio_ack_i, mmio_rdata_i, data_addr_i[31:SRAM_AW+2], data_addr_i[1:0],
                            MMIO_BASE, MMIO_MASK, TIMEOUT};
`endif
endmodule

// File: tb/tb_n2_dmem_bridge.sv
// tb_n2_dmem_bridge: directed scoreboard bench for n2_dmem_bridge (MMIO tests when N2_DMEM_MMIO_EN is set).
module tb_n2_dmem_bridge;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic [3:0]  data_wstrb_i = 4'h0;
    logic        data_gnt_o;
    logic        data_ready_o;
    logic [31:0] data_rdata_o;
    logic        sram_cs_o;
    logic [3:0]  sram_we_o;
    logic [13:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i = 32'h0;
    logic        mmio_req_o;
    logic        mmio_we_o;
    logic [31:0] mmio_addr_o;
    logic [31:0] mmio_wdata_o;
    logic [3:0]  mmio_wstrb_o;
    logic        mmio_ack_i = 1'b0;
    logic [31:0] mmio_rdata_i = 32'h0;
    logic        bus_err_o;

    n2_dmem_bridge dut (
        .clk(clk), .resetn(resetn),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_wstrb_i(data_wstrb_i),
        .data_gnt_o(data_gnt_o), .data_ready_o(data_ready_o), .data_rdata_o(data_rdata_o),
        .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .mmio_req_o(mmio_req_o), .mmio_we_o(mmio_we_o), .mmio_addr_o(mmio_addr_o),
        .mmio_wdata_o(mmio_wdata_o), .mmio_wstrb_o(mmio_wstrb_o),
        .mmio_ack_i(mmio_ack_i), .mmio_rdata_i(mmio_rdata_i), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (sram_cs_o) begin
            for (int b = 0; b < 4; b++)
                if (sram_we_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            sram_rdata_i <= mem[sram_addr_o];
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
    } exp_t;
    exp_t q[$];
    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (q.size() == 0) chk("ready_unexpected", {31'b0, data_ready_o}, 32'h0);
        else if (data_ready_o) begin
            e = q.pop_front();
            chk("rsp_cycle", cyc, e.at);
            chk("rsp_data", data_rdata_o, e.data);
            chk("rsp_err", {31'b0, bus_err_o}, {31'b0, e.err});
        end else if (cyc > q[0].at) begin
            e = q.pop_front();
            chk("rsp_missing", {31'b0, data_ready_o}, 32'h1);
        end
        if (!data_ready_o) chk("err_without_ready", {31'b0, bus_err_o}, 32'h0);
    endtask

    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        @(negedge clk);
        mon();
        data_req_i   = req;
        data_we_i    = we;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        data_wstrb_i = strb;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        idle(3);
        chk("rst_gnt", {31'b0, data_gnt_o}, 32'h0);
        chk("rst_ready", {31'b0, data_ready_o}, 32'h0);
        chk("rst_rdata", data_rdata_o, 32'h0);
        chk("rst_mmio_req", {31'b0, mmio_req_o}, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err_o}, 32'h0);
        resetn = 1'b1;
        idle(2);

        step(1'b1, 1'b1, 32'h100, 32'h1122_3344, 4'hF);
        chk("sw_gnt", {31'b0, data_gnt_o}, 32'h1);
        chk("sw_cs", {31'b0, sram_cs_o}, 32'h1);
        chk("sw_we", {28'b0, sram_we_o}, 32'hF);
        chk("sw_addr", {18'b0, sram_addr_o}, 32'h40);
        chk("sw_wdata", sram_wdata_o, 32'h1122_3344);
        q.push_back('{32'h0, 1'b0, cyc + 1});
        step(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        chk("lw_gnt", {31'b0, data_gnt_o}, 32'h1);
        chk("lw_we", {28'b0, sram_we_o}, 32'h0);
        q.push_back('{32'h1122_3344, 1'b0, cyc + 1});
        idle(1);

        step(1'b1, 1'b1, 32'h103, 32'hAAAA_AAAA, 4'b1000);
        chk("sb_we", {28'b0, sram_we_o}, 32'h8);
        chk("sb_addr", {18'b0, sram_addr_o}, 32'h40);
        q.push_back('{32'h0, 1'b0, cyc + 1});
        step(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        q.push_back('{32'hAA22_3344, 1'b0, cyc + 1});
        step(1'b1, 1'b1, 32'h104, 32'h0BAD_F00D, 4'hF);
        q.push_back('{32'h0, 1'b0, cyc + 1});
        idle(1);

        for (int i = 0; i < 8; i++) begin
            a = 32'h200 + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            d = $urandom;
            step(1'b1, 1'b1, a, d, 4'hF);
            q.push_back('{32'h0, 1'b0, cyc + 1});
            step(1'b1, 1'b0, a, 32'h0, 4'h0);
            chk("rnd_gnt", {31'b0, data_gnt_o}, 32'h1);
            q.push_back('{d, 1'b0, cyc + 1});
        end
        idle(1);

`ifdef N2_DMEM_MMIO_EN
        step(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0);
        chk("mm_gnt", {31'b0, data_gnt_o}, 32'h1);
        chk("mm_no_cs", {31'b0, sram_cs_o}, 32'h0);
        q.push_back('{32'h5A5A_5A5A, 1'b0, cyc + 4});
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
            chk("mm_gnt_wait", {31'b0, data_gnt_o}, 32'h0);
            chk("mm_req", {31'b0, mmio_req_o}, 32'h1);
            chk("mm_addr", mmio_addr_o, 32'h1000_0004);
        end
        mmio_ack_i = 1'b1;
        mmio_rdata_i = 32'h5A5A_5A5A;
        step(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        mmio_ack_i = 1'b0;
        chk("mm_req_drop", {31'b0, mmio_req_o}, 32'h0);
        chk("mm_gnt_resp", {31'b0, data_gnt_o}, 32'h1);
        q.push_back('{32'hAA22_3344, 1'b0, cyc + 1});
        idle(2);

        step(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        q.push_back('{32'hAA22_3344, 1'b0, cyc + 1});
        step(1'b1, 1'b0, 32'h1000_0008, 32'h0, 4'h0);
        chk("mix_mm_gnt", {31'b0, data_gnt_o}, 32'h1);
        q.push_back('{32'h1357_2468, 1'b0, cyc + 2});
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mmio_ack_i = 1'b1;
        mmio_rdata_i = 32'h1357_2468;
        step(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
        mmio_ack_i = 1'b0;
        chk("mix_resp_gnt", {31'b0, data_gnt_o}, 32'h1);
        q.push_back('{32'h0BAD_F00D, 1'b0, cyc + 1});
        idle(2);

        step(1'b1, 1'b1, 32'h1000_0010, 32'h1234_5678, 4'hF);
        q.push_back('{32'h0, 1'b1, cyc + 257});
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("to_req", {31'b0, mmio_req_o}, 32'h1);
        chk("to_we", {31'b0, mmio_we_o}, 32'h1);
        chk("to_wdata", mmio_wdata_o, 32'h1234_5678);
        chk("to_wstrb", {28'b0, mmio_wstrb_o}, 32'hF);
        idle(259);

        step(1'b1, 1'b0, 32'h1000_0014, 32'h0, 4'h0);
        q.push_back('{32'h600D_CAFE, 1'b0, cyc + 257});
        idle(255);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mmio_ack_i = 1'b1;
        mmio_rdata_i = 32'h600D_CAFE;
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mmio_ack_i = 1'b0;
        idle(2);

        step(1'b1, 1'b0, 32'h1000_0018, 32'h0, 4'h0);
        q.push_back('{32'hDEAD_BEEF, 1'b1, cyc + 257});
        idle(260);

        step(1'b1, 1'b0, 32'h1000_001C, 32'h0, 4'h0);
        idle(2);
        chk("rw_req_before", {31'b0, mmio_req_o}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("rw_req_async_drop", {31'b0, mmio_req_o}, 32'h0);
        idle(2);
        resetn = 1'b1;
        idle(6);
        chk("rw_req_after", {31'b0, mmio_req_o}, 32'h0);
`else
        step(1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF);
        q.push_back('{32'h0, 1'b0, cyc + 1});
        step(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0);
        chk("nomm_gnt", {31'b0, data_gnt_o}, 32'h1);
        chk("nomm_cs", {31'b0, sram_cs_o}, 32'h1);
        chk("nomm_addr", {18'b0, sram_addr_o}, 32'h1);
        q.push_back('{32'hCAFE_F00D, 1'b0, cyc + 1});
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("nomm_req", {31'b0, mmio_req_o}, 32'h0);
        chk("nomm_maddr", mmio_addr_o, 32'h0);
        chk("nomm_mwe", {31'b0, mmio_we_o}, 32'h0);
        idle(2);
`endif
        idle(2);
        chk("q_drain", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/n2_dmem_bridge.md
# n2_dmem_bridge

Data-memory bridge directly downstream of the load/store unit. It accepts the LSU's req/gnt request channel and returns exactly one in-order `data_ready_o` pulse per granted request, loads and stores alike. Word accesses go to a single-port synchronous SRAM with 1-cycle read latency, and an optional MMIO window goes to a variable-latency peripheral port with timeout protection.

## Interface
Parameters:
- `SRAM_AW`, 14: SRAM word-address width (64 KiB).
- `MMIO_BASE`, 32'h1000_0000: MMIO window base.
- `MMIO_MASK`, 32'hF000_0000: address is MMIO when `(addr & MMIO_MASK) == MMIO_BASE`.
- `TIMEOUT`, 255: maximum MMIO wait cycles before the bridge forces an error response (8-bit counter).

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `data_req_i`, in, 1: LSU request valid.
- `data_we_i`, in, 1: store when 1, load when 0.
- `data_addr_i`, in, 32: byte address.
- `data_wdata_i`, in, 32: lane-replicated store data.
- `data_wstrb_i`, in, 4: byte strobes; all zero for loads.
- `data_gnt_o`, out, 1: request accepted this cycle (combinational).
- `data_ready_o`, out, 1: response pulse, in request order.
- `data_rdata_o`, out, 32: read data, valid with `data_ready_o`.
- `sram_cs_o`, out, 1: SRAM select.
- `sram_we_o`, out, 4: SRAM byte write enables.
- `sram_addr_o`, out, SRAM_AW: SRAM word address, `data_addr_i[SRAM_AW+1:2]`.
- `sram_wdata_o`, out, 32: SRAM write data.
- `sram_rdata_i`, in, 32: SRAM read data, 1 cycle after `sram_cs_o`.
- `mmio_req_o`, out, 1: MMIO request, held until ack or timeout.
- `mmio_we_o`, out, 1: MMIO write.
- `mmio_addr_o`, out, 32: MMIO address.
- `mmio_wdata_o`, out, 32: MMIO write data.
- `mmio_wstrb_o`, out, 4: MMIO strobes.
- `mmio_ack_i`, in, 1: MMIO completion.
- `mmio_rdata_i`, in, 32: MMIO read data, valid with ack.
- `bus_err_o`, out, 1: one-cycle pulse coincident with a timed-out response.

## Operation
- FSM states: `IDLE`, `WAIT`, `RESP`.
- Grant rule: `data_gnt_o = data_req_i & (state==IDLE | state==RESP)`.
- SRAM hit granted:
  - `sram_cs_o`, `sram_we_o = data_wstrb_i & {4{data_we_i}}`, address and wdata are driven combinationally in the grant cycle.
  - A registered pending flag and registered `we` produce the response.
  - State is unchanged.
- MMIO hit granted:
  - The bridge latches addr, wdata, wstrb and we into MMIO registers.
  - The FSM enters `WAIT` and clears the timeout counter.
- `WAIT`:
  - `mmio_req_o=1`; the counter increments each cycle without ack.
  - On `mmio_ack_i`, the bridge latches `mmio_rdata_i` and the FSM goes to `RESP`.
  - When the counter reaches `TIMEOUT` without ack, the bridge latches 32'hDEAD_BEEF, sets the error flag and the FSM goes to `RESP`.
  - Ack in the same cycle as timeout: ack wins, no error.
- `RESP`:
  - `data_ready_o=1` with the latched data; `bus_err_o` equals the error flag.
  - The FSM returns to `IDLE`.
  - A new request may be granted in this cycle.
- `data_rdata_o` is forced to 0 for store responses on both paths.
- Ordering is guaranteed because no grant occurs in `WAIT`. An SRAM response pending from cycle T-1 is delivered while the MMIO access is issued.

## Timing
- Reset values: all outputs 0, state `IDLE`, pending flag and counter 0.
- Reset mid-`WAIT` drops `mmio_req_o` immediately; no response is produced.
- SRAM: grant at T, `data_ready_o` at T+1. Throughput is one access per cycle with no bubbles.
- MMIO: grant at T, `mmio_req_o` from T+1; ack at T+k gives `data_ready_o` at T+k+1. Minimum latency is 2.
- Timeout: with no ack, `data_ready_o` and `bus_err_o` are asserted at T+TIMEOUT+2.
- `data_ready_o` never asserts twice in one cycle. The SRAM pending response and `RESP` never coincide, because no grant occurs in `WAIT`.

## Configuration
- `N2_DMEM_MMIO_EN` defined: MMIO decode, the `WAIT`/`RESP` path, the timeout counter and `bus_err_o` are present.
- Not defined:
  - Every address goes to SRAM (upper bits ignored).
  - `mmio_*` outputs and `bus_err_o` are tied 0; the `mmio_*` inputs are ignored.
  - FSM reduces to `IDLE` only, so `data_gnt_o = data_req_i`.

## Structure
- Shared package `NanoCore_pkg` holds:
  - enum `dmem_state_e` (`IDLE`, `WAIT`, `RESP`);
  - constant `DMEM_ERR_DATA = 32'hDEAD_BEEF`.
- There is no sub-module. Decode, FSM and counter sit in one module; the counter is too small to justify a separate block.

## Test plan
- Back-to-back SRAM: SW 0x11223344 to 0x100, LW 0x100, with requests on consecutive cycles. Both are granted immediately, with ready at T+1 and T+2. The load returns 0x11223344 and the store returns 0.
- SB with strobes: SB 0xAA to 0x103 (wstrb 4'b1000) → `sram_we_o=4'b1000` and `sram_addr_o=0x40`.
- MMIO read: LW 0x1000_0004 with ack after 3 cycles and rdata 0x5A5A5A5A. `mmio_req_o` is high 3 cycles and `data_gnt_o` is low throughout. `data_ready_o` asserts at T+4 with 0x5A5A5A5A and `bus_err_o=0`.
- Mixed ordering: SRAM LW at T, MMIO LW at T+1 (ack at T+2), SRAM LW granted in the `RESP` cycle T+3. Three ready pulses arrive at T+1, T+3 and T+4, in order.
- Timeout: MMIO SW with no ack and TIMEOUT=255. `data_ready_o` and `bus_err_o` both pulse at T+257; a second test asserts ack exactly at the timeout cycle and requires `bus_err_o=0`.
- Reset in `WAIT`: deassert `resetn` mid-MMIO. `mmio_req_o` drops asynchronously and no `data_ready_o` appears after release.
